morse_char_buffer: RTL and testbench

- Parametrised successor to the fixed 8-digit character register in the Morse encoder path.
- Stores up to DIGITS decoded character codes, newest in digit 0, and drives a flat seven-segment bus.
- Supports backspace, clear, overflow reporting and an ordered playback port with a valid/ready handshake, so the stored text can be streamed to a downstream Morse encoder.
- Sits between the character decoder (write side) and both the display driver and the encoder.

---
 rtl/morse_char_buffer.sv | 149 ++++++++++++++
 tb/tb_morse_char_buffer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/morse_char_buffer.sv
// morse_char_buffer
//   Holds up to DIGITS character codes. Digit 0 is the newest. The block drives
//   a flat seven-segment bus and can stream the stored text, oldest character
//   first, to a downstream Morse encoder over a valid/ready handshake.
//
// Ports
//   clk, rst       system clock, synchronous active-low reset
//   en             block enable; when low, all command edges are ignored
//   wr_valid       write request level; a rising edge writes wr_code
//   wr_code        character code to write
//   bksp           backspace level; a rising edge deletes the newest character
//   clr            clear level; a rising edge empties the buffer and aborts playback
//   play_start     a rising edge starts playback when the buffer is not empty
//   play_ready     the downstream side accepts play_code
//   play_valid     play_code is valid (high for the whole playback)
//   play_code      character being played; BLANK when not playing
//   play_done      one-cycle pulse after the last character has been accepted
//   overflow       one-cycle pulse when a write is dropped because the buffer is full
//   count          number of stored characters
//   full, empty    count==DIGITS, count==0
//   seg_out        digit i is at [i*CODE_W +: CODE_W]
module morse_char_buffer #(
    parameter int                DIGITS = 8,
    parameter int                CODE_W = 8,
    parameter logic [CODE_W-1:0] BLANK  = {CODE_W{1'b0}}
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       wr_valid,
    input  logic [CODE_W-1:0]          wr_code,
    input  logic                       bksp,
    input  logic                       clr,
    input  logic                       play_start,
    input  logic                       play_ready,
    output logic                       play_valid,
    output logic [CODE_W-1:0]          play_code,
    output logic                       play_done,
    output logic                       overflow,
    output logic [$clog2(DIGITS+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic [DIGITS*CODE_W-1:0]   seg_out
);

    localparam int CNT_W = $clog2(DIGITS+1);
    localparam int IDX_W = $clog2(DIGITS);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t                        state, state_nxt;
    logic [DIGITS-1:0][CODE_W-1:0] dig;
    logic [IDX_W-1:0]              idx;
    logic                          prev_wr, prev_bksp, prev_clr, prev_play;

    // The history registers track the raw levels even while en is low, so a
    // level that went high while disabled is not seen as an edge on re-enable.
    logic e_wr, e_bksp, e_clr, e_play;
    assign e_wr   = en & wr_valid   & ~prev_wr;
    assign e_bksp = en & bksp       & ~prev_bksp;
    assign e_clr  = en & clr        & ~prev_clr;
    assign e_play = en & play_start & ~prev_play;

    // Priority clr > bksp > wr > play_start; only the winning edge acts.
    // Backspace, write and play start are only honoured while idle.
    logic idle, do_bksp, do_wr, do_start, accept;
    assign idle     = (state == IDLE);
    assign do_bksp  = idle & e_bksp & ~e_clr;
    assign do_wr    = idle & e_wr & ~e_bksp & ~e_clr;
    assign do_start = idle & e_play & ~e_wr & ~e_bksp & ~e_clr & ~empty;
    // en low freezes playback; a clear in the same cycle wins over the handshake.
    assign accept   = (state == PLAY) & en & play_ready & ~e_clr;

    assign full    = (count == CNT_W'(DIGITS));
    assign empty   = (count == '0);
    assign seg_out = dig;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (do_start) state_nxt = PLAY;
            PLAY: if (e_clr || (accept && idx == '0)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        play_valid = (state == PLAY);
        play_code  = play_valid ? dig[idx] : BLANK;
    end

    // Storage, playback index, edge history and status pulses
    always_ff @(posedge clk) begin
        if (!rst) begin
            dig       <= {DIGITS{BLANK}};
            count     <= '0;
            idx       <= '0;
            overflow  <= 1'b0;
            play_done <= 1'b0;
            prev_wr   <= 1'b0;
            prev_bksp <= 1'b0;
            prev_clr  <= 1'b0;
            prev_play <= 1'b0;
        end else begin
            prev_wr   <= wr_valid;
            prev_bksp <= bksp;
            prev_clr  <= clr;
            prev_play <= play_start;
            overflow  <= 1'b0;
            play_done <= 1'b0;

            if (e_clr) begin
                dig   <= {DIGITS{BLANK}};
                count <= '0;
            end else if (do_bksp) begin
                if (!empty) begin
                    for (int i = 0; i < DIGITS-1; i++) dig[i] <= dig[i+1];
                    dig[DIGITS-1] <= BLANK;
                    count <= count - CNT_W'(1);
                end
            end else if (do_wr) begin
                if (!full) begin
                    for (int i = DIGITS-1; i > 0; i--) dig[i] <= dig[i-1];
                    dig[0] <= wr_code;
                    count  <= count + CNT_W'(1);
                end else begin
                    overflow <= 1'b1;
                end
            end

            // Playback walks from the oldest stored digit down to digit 0.
            if (do_start) begin
                idx <= IDX_W'(count - CNT_W'(1));
            end else if (accept) begin
                if (idx == '0) play_done <= 1'b1;
                else           idx <= idx - IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_morse_char_buffer.sv
module tb_morse_char_buffer;
    localparam int D = 8;
    localparam int W = 8;

    logic clk = 0, rst = 0, en = 0, wr_valid = 0, bksp = 0, clr = 0;
    logic play_start = 0, play_ready = 0;
    logic [W-1:0] wr_code = '0;
    logic play_valid, play_done, overflow, full, empty;
    logic [W-1:0] play_code;
    logic [$clog2(D+1)-1:0] count;
    logic [D*W-1:0] seg_out;

    morse_char_buffer #(.DIGITS(D), .CODE_W(W)) dut (
        .clk(clk), .rst(rst), .en(en), .wr_valid(wr_valid), .wr_code(wr_code),
        .bksp(bksp), .clr(clr), .play_start(play_start), .play_ready(play_ready),
        .play_valid(play_valid), .play_code(play_code), .play_done(play_done),
        .overflow(overflow), .count(count), .full(full), .empty(empty),
        .seg_out(seg_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    // Reference model: text as a queue, newest character at index 0.
    typedef struct {int tag; int cnt; logic [D*W-1:0] seg; logic pv; logic [W-1:0] pc;} snap_t;
    typedef struct {int tag; logic [W-1:0] code;} code_t;
    snap_t snap_q[$];
    code_t code_q[$];
    int    ovf_q[$];
    int    done_q[$];

    logic [W-1:0] mbuf[$];
    bit playing = 0;
    int pidx = 0;
    bit pw = 0, pb = 0, pc = 0, pp = 0;

    function automatic snap_t make_snap(input int tag);
        snap_t s;
        s.tag = tag;
        s.cnt = mbuf.size();
        s.seg = '0;
        for (int i = 0; i < mbuf.size(); i++) s.seg[i*W +: W] = mbuf[i];
        s.pv = playing;
        s.pc = playing ? mbuf[pidx] : '0;
        return s;
    endfunction

    // Apply one cycle of inputs, predict what the next clock edge does, then
    // advance past that edge.
    task automatic step(input bit r, input bit e, input bit w, input logic [W-1:0] c,
                        input bit b, input bit cl, input bit p, input bit rd);
        bit ew, eb, ec, ep;
        rst = r; en = e; wr_valid = w; wr_code = c; bksp = b; clr = cl;
        play_start = p; play_ready = rd;
        if (!r) begin
            mbuf.delete();
            playing = 0; pidx = 0;
            pw = 0; pb = 0; pc = 0; pp = 0;
        end else begin
            ew = e && w && !pw;  eb = e && b && !pb;
            ec = e && cl && !pc; ep = e && p && !pp;
            pw = w; pb = b; pc = cl; pp = p;
            if (ec) begin
                mbuf.delete();
                playing = 0;
            end else if (playing) begin
                if (e && rd) begin
                    code_q.push_back('{cyc, mbuf[pidx]});
                    if (pidx == 0) begin
                        playing = 0;
                        done_q.push_back(cyc + 1);
                    end else pidx--;
                end
            end else if (eb) begin
                if (mbuf.size() > 0) void'(mbuf.pop_front());
            end else if (ew) begin
                if (mbuf.size() < D) mbuf.push_front(c);
                else ovf_q.push_back(cyc + 1);
            end else if (ep && mbuf.size() > 0) begin
                playing = 1;
                pidx = mbuf.size() - 1;
            end
        end
        snap_q.push_back(make_snap(cyc + 1));
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares DUT outputs against expectations, decoupled from stimulus.
    always @(negedge clk) begin
        bit exp_p;
        if (snap_q.size() > 0 && snap_q[0].tag < cyc) begin
            chk("snapshot_stale", 64'(snap_q[0].tag), 64'(cyc));
            void'(snap_q.pop_front());
        end
        if (snap_q.size() > 0 && snap_q[0].tag == cyc) begin
            snap_t s;
            s = snap_q.pop_front();
            chk("count", 64'(count), 64'(s.cnt));
            chk("seg_out", seg_out, s.seg);
            chk("full", 64'(full), 64'(s.cnt == D));
            chk("empty", 64'(empty), 64'(s.cnt == 0));
            chk("play_valid", 64'(play_valid), 64'(s.pv));
            chk("play_code", 64'(play_code), 64'(s.pc));
            exp_p = (ovf_q.size() > 0 && ovf_q[0] == cyc);
            if (exp_p) void'(ovf_q.pop_front());
            chk("overflow", 64'(overflow), 64'(exp_p));
            exp_p = (done_q.size() > 0 && done_q[0] == cyc);
            if (exp_p) void'(done_q.pop_front());
            chk("play_done", 64'(play_done), 64'(exp_p));
        end
        if (code_q.size() > 0 && code_q[0].tag == cyc) begin
            code_t e;
            e = code_q.pop_front();
            chk("handshake", 64'(play_valid && play_ready), 64'd1);
            chk("accepted_code", 64'(play_code), 64'(e.code));
        end
    end

    task automatic wr(input logic [W-1:0] c);
        step(1, 1, 1, c, 0, 0, 0, 0);
        step(1, 1, 0, c, 0, 0, 0, 0);
    endtask

    task automatic idle(input int n, input bit rd);
        for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0, 0, rd);
    endtask

    initial begin
        // reset and three writes
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        idle(1, 0);
        wr(8'h11); wr(8'h22); wr(8'h33);

        // fill, overflow, backspace
        step(1, 1, 0, 0, 0, 1, 0, 0); idle(1, 0);
        for (int i = 1; i <= 9; i++) wr(8'(i));
        idle(2, 0);
        step(1, 1, 0, 0, 1, 0, 0, 0); idle(1, 0);

        // held level writes once; edge while disabled is lost
        step(1, 1, 0, 0, 0, 1, 0, 0); idle(1, 0);
        for (int i = 0; i < 20; i++) step(1, 1, 1, 8'h55, 0, 0, 0, 0);
        idle(1, 0);
        step(1, 0, 1, 8'h66, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 8'h66, 0, 0, 0, 0);
        idle(1, 0);

        // playback with toggling ready
        step(1, 1, 0, 0, 0, 1, 0, 0); idle(1, 0);
        wr(8'hA1); wr(8'hB2); wr(8'hC3);
        step(1, 1, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0, 0, 0, i[0]);
        idle(2, 0);

        // simultaneous clr/bksp/wr with four stored; clear mid-playback
        wr(8'hD4);
        step(1, 1, 1, 8'hEE, 1, 1, 0, 0); idle(1, 0);
        wr(8'h01); wr(8'h02); wr(8'h03);
        step(1, 1, 0, 0, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 1, 0, 1);
        idle(3, 1);

        // reset mid-playback, then play on empty buffer
        for (int i = 0; i < 5; i++) wr(8'(8'h40 + i));
        step(1, 1, 0, 0, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        idle(1, 0);
        step(1, 1, 0, 0, 0, 0, 1, 1);
        idle(3, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(199) != 0, $urandom_range(9) != 0,
                 $urandom_range(2) == 0, 8'($urandom), $urandom_range(5) == 0,
                 $urandom_range(24) == 0, $urandom_range(7) == 0,
                 $urandom_range(1) == 0);
        end

        @(negedge clk);
        #1;
        chk("pending_snapshots", 64'(snap_q.size()), 64'd0);
        chk("pending_codes", 64'(code_q.size()), 64'd0);
        chk("pending_overflow", 64'(ovf_q.size()), 64'd0);
        chk("pending_done", 64'(done_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
